// File: rtl/fmap_pingpong_buffer_pkg.sv
// Shared feature-map constants and bank-select type used by the
// convolution, patch-latch and ping-pong buffer blocks.
package fmap_pingpong_buffer_pkg;

    localparam int unsigned FMAP_DATA_W   = 8;
    localparam int unsigned FMAP_ADDR_LEN = 9;
    localparam int unsigned FMAP_DEPTH    = 28 * 28;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_e;

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/fmap_pingpong_buffer_bank.sv
// One feature-map bank: single write port, two registered read ports.
// A read port that is not enabled outputs zero on the next cycle.
module fmap_bank
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = FMAP_DEPTH,
    parameter int unsigned ADDR_LEN = FMAP_ADDR_LEN
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [ADDR_LEN:0]             i_wr_addr,
    input  logic signed [FMAP_DATA_W-1:0] i_wr_data,
    input  logic                          i_rd_en1,
    input  logic [ADDR_LEN:0]             i_rd_addr1,
    input  logic                          i_rd_en2,
    input  logic [ADDR_LEN:0]             i_rd_addr2,
    output logic signed [FMAP_DATA_W-1:0] o_rd_data1,
    output logic signed [FMAP_DATA_W-1:0] o_rd_data2
);

    logic signed [FMAP_DATA_W-1:0] r_mem [DEPTH];
    logic signed [FMAP_DATA_W-1:0] r_rd_data1;
    logic signed [FMAP_DATA_W-1:0] r_rd_data2;

    // Storage is never reset; callers guarantee in-range addresses.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
        end else begin
            r_rd_data1 <= i_rd_en1 ? r_mem[i_rd_addr1] : '0;
            r_rd_data2 <= i_rd_en2 ? r_mem[i_rd_addr2] : '0;
        end
    end

    assign o_rd_data1 = r_rd_data1;
    assign o_rd_data2 = r_rd_data2;

endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Ping-pong feature-map buffer: producer fills one bank while the consumer
// reads the other; banks exchange once the frame is complete and released.
module fmap_pingpong_buffer
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = FMAP_DEPTH,
    parameter int unsigned ADDR_LEN = FMAP_ADDR_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [ADDR_LEN:0]             wr_addr,
    input  logic signed [FMAP_DATA_W-1:0] wr_data,
    input  logic                          frame_done,
    input  logic [ADDR_LEN:0]             rd_addr1,
    input  logic [ADDR_LEN:0]             rd_addr2,
    output logic signed [FMAP_DATA_W-1:0] rd_data1,
    output logic signed [FMAP_DATA_W-1:0] rd_data2,
    input  logic                          cons_release,
    output logic                          rd_valid,
    output logic                          wr_full,
    output logic                          swap,
    output logic [ADDR_LEN:0]             wr_count,
    output logic                          err
);

    localparam int unsigned      ADDR_W  = ADDR_LEN + 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    bank_sel_e         r_wsel;
    logic              r_rd_valid;
    logic              r_wr_full;
    logic [ADDR_W-1:0] r_wr_count;
    logic              r_err;

    logic      w_wr_accept;
    logic      w_wr_drop;
    logic      w_fd_set;
    logic      w_fd_err;
    logic      w_swap;
    bank_sel_e w_rsel;
    logic      w_rd_ok1;
    logic      w_rd_ok2;

    logic signed [FMAP_DATA_W-1:0] w_b0_rd1, w_b0_rd2;
    logic signed [FMAP_DATA_W-1:0] w_b1_rd1, w_b1_rd2;

    assign w_wr_accept = wr_en && !r_wr_full && (wr_addr < DEPTH_A);
    assign w_wr_drop   = wr_en && !w_wr_accept;
    assign w_fd_set    = frame_done && !r_wr_full;
    assign w_fd_err    = frame_done && r_wr_full;
    assign w_swap      = r_wr_full && (!r_rd_valid || cons_release);

    // Read side always uses the pre-swap select and valid.
    assign w_rsel   = other_bank(r_wsel);
    assign w_rd_ok1 = r_rd_valid && (rd_addr1 < DEPTH_A);
    assign w_rd_ok2 = r_rd_valid && (rd_addr2 < DEPTH_A);

    // Bank-role, frame-state, write-count and sticky-error control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsel     <= BANK_0;
            r_rd_valid <= 1'b0;
            r_wr_full  <= 1'b0;
            r_wr_count <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_wr_drop || w_fd_err) begin
                r_err <= 1'b1;
            end
            if (w_swap) begin
                r_wsel     <= other_bank(r_wsel);
                r_rd_valid <= 1'b1;
                r_wr_full  <= 1'b0;
                r_wr_count <= '0;
            end else begin
                if (cons_release) begin
                    r_rd_valid <= 1'b0;
                end
                if (w_fd_set) begin
                    r_wr_full <= 1'b1;
                end
                if (w_wr_accept) begin
                    r_wr_count <= r_wr_count + ADDR_W'(1);
                end
            end
        end
    end

    fmap_bank #(
        .DEPTH    (DEPTH),
        .ADDR_LEN (ADDR_LEN)
    ) u_bank0 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (w_wr_accept && (r_wsel == BANK_0)),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_en1   (w_rd_ok1 && (w_rsel == BANK_0)),
        .i_rd_addr1 (rd_addr1),
        .i_rd_en2   (w_rd_ok2 && (w_rsel == BANK_0)),
        .i_rd_addr2 (rd_addr2),
        .o_rd_data1 (w_b0_rd1),
        .o_rd_data2 (w_b0_rd2)
    );

    fmap_bank #(
        .DEPTH    (DEPTH),
        .ADDR_LEN (ADDR_LEN)
    ) u_bank1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (w_wr_accept && (r_wsel == BANK_1)),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_en1   (w_rd_ok1 && (w_rsel == BANK_1)),
        .i_rd_addr1 (rd_addr1),
        .i_rd_en2   (w_rd_ok2 && (w_rsel == BANK_1)),
        .i_rd_addr2 (rd_addr2),
        .o_rd_data1 (w_b1_rd1),
        .o_rd_data2 (w_b1_rd2)
    );

    // Disabled bank ports return zero, so merging is a plain OR.
    assign rd_data1 = w_b0_rd1 | w_b1_rd1;
    assign rd_data2 = w_b0_rd2 | w_b1_rd2;
    assign rd_valid = r_rd_valid;
    assign wr_full  = r_wr_full;
    assign swap     = w_swap;
    assign wr_count = r_wr_count;
    assign err      = r_err;

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Self-checking bench for fmap_pingpong_buffer against a frame-level model.
module tb_fmap_pingpong_buffer;

    localparam int D = 784;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic              frame_done;
    logic [9:0]        rd_addr1, rd_addr2;
    logic signed [7:0] rd_data1, rd_data2;
    logic              cons_release;
    logic              rd_valid, wr_full, swap, err;
    logic [9:0]        wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: two frame stores, which one the producer fills, and flags.
    logic [7:0] m_mem [2][D];
    bit         m_wsel, m_rv, m_full, m_err;
    int         m_cnt;
    logic [7:0] m_rd1, m_rd2;

    always #5 clk = ~clk;

    fmap_pingpong_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .cons_release (cons_release),
        .rd_valid     (rd_valid),
        .wr_full      (wr_full),
        .swap         (swap),
        .wr_count     (wr_count),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wsel = 0; m_rv = 0; m_full = 0; m_err = 0; m_cnt = 0;
        m_rd1 = 8'h00; m_rd2 = 8'h00;
    endtask

    task automatic chk_regs();
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_rv});
        chk("wr_full",  {31'b0, wr_full},  {31'b0, m_full});
        chk("wr_count", {22'b0, wr_count}, 32'(m_cnt));
        chk("err",      {31'b0, err},      {31'b0, m_err});
        chk("rd_data1", {24'b0, rd_data1}, {24'b0, m_rd1});
        chk("rd_data2", {24'b0, rd_data2}, {24'b0, m_rd2});
    endtask

    // One clock: drive inputs, check swap before the edge, update model, check after.
    task automatic cyc(input bit r, input bit we, input int wa, input logic [7:0] wd,
                       input bit fd, input bit rel, input int a1, input int a2);
        bit sw, set_full;
        rst = r; wr_en = we; wr_addr = 10'(wa); wr_data = wd;
        frame_done = fd; cons_release = rel; rd_addr1 = 10'(a1); rd_addr2 = 10'(a2);
        #1;
        chk("swap", {31'b0, swap}, {31'b0, m_full && (!m_rv || rel)});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_rd1 = (m_rv && a1 < D) ? m_mem[!m_wsel][a1] : 8'h00;
            m_rd2 = (m_rv && a2 < D) ? m_mem[!m_wsel][a2] : 8'h00;
            sw = m_full && (!m_rv || rel);
            set_full = 0;
            if (we) begin
                if (!m_full && wa < D) begin
                    m_mem[m_wsel][wa] = wd;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (fd) begin
                if (m_full) m_err = 1;
                else set_full = 1;
            end
            if (sw) begin
                m_wsel = !m_wsel; m_rv = 1; m_full = 0; m_cnt = 0;
            end else begin
                if (rel) m_rv = 0;
                if (set_full) m_full = 1;
            end
        end
        #1;
        chk_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 8'h00, 0, 0, int'($urandom_range(0, 899)), int'($urandom_range(0, 899)));
    endtask

    // mode 0: data = addr[7:0]; mode 1: 0xAA; mode 2: random.
    task automatic wr_frame(input int mode, input int n);
        logic [7:0] d;
        for (int a = 0; a < n; a++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            d = (mode == 0) ? 8'(a) : (mode == 1) ? 8'hAA : 8'($urandom);
            cyc(0, 1, a, d, 0, 0, int'($urandom_range(0, 899)), int'($urandom_range(0, 899)));
        end
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; frame_done = 0;
        cons_release = 0; rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_regs();
        chk("reset_swap", {31'b0, swap}, 32'd0);

        // Frame 1, swap into an empty read side.
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
        wr_frame(0, D);
        cyc(0, 0, 0, 8'h00, 1, 0, 0, 0);
        chk("plan_full", {31'b0, wr_full}, 32'd1);
        cyc(0, 0, 0, 8'h00, 0, 0, 5, 783);
        chk("plan_swapped_rv", {31'b0, rd_valid}, 32'd1);
        chk("plan_swap_cycle_rd", {24'b0, rd_data1}, 32'd0);
        cyc(0, 0, 0, 8'h00, 0, 0, 5, 783);
        chk("plan_rd1", {24'b0, rd_data1}, 32'h05);
        chk("plan_rd2", {24'b0, rd_data2}, 32'h0F);

        // Frame 2 completes while frame 1 is still being read.
        wr_frame(1, D);
        cyc(0, 0, 0, 8'h00, 1, 0, 10, 20);
        idle(5);
        cyc(0, 0, 0, 8'h00, 0, 0, 300, 700);
        chk("plan_old_rd", {24'b0, rd_data1}, 32'(8'(300)));
        cyc(0, 0, 0, 8'h00, 0, 1, 300, 700);
        chk("plan_pre_swap_rd", {24'b0, rd_data1}, 32'(8'(300)));
        cyc(0, 0, 0, 8'h00, 0, 0, 300, 700);
        chk("plan_new_rd", {24'b0, rd_data1}, 32'hAA);
        chk("plan_err_clean", {31'b0, err}, 32'd0);

        // Protocol errors: out-of-range write, write when full, frame_done when full.
        cyc(0, 1, 784, 8'h11, 0, 0, 800, 1);
        chk("plan_err_set", {31'b0, err}, 32'd1);
        cyc(0, 1, 3, 8'h33, 1, 0, 3, 800);
        cyc(0, 1, 4, 8'h44, 0, 0, 3, 4);
        cyc(0, 0, 0, 8'h00, 1, 0, 3, 4);
        chk("plan_cnt_hold", {22'b0, wr_count}, 32'd1);
        idle(3);
        cyc(0, 0, 0, 8'h00, 0, 1, 3, 4);
        idle(3);

        // Release without a pending frame drops valid; reads then return zero.
        cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 3);
        chk("plan_invalid_rd", {24'b0, rd_data2}, 32'd0);
        cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 820)), 8'($urandom),
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 39) == 0),
                int'($urandom_range(0, 899)), int'($urandom_range(0, 899)));
        end

        // Mid-frame reset, then a clean frame.
        cyc(0, 0, 0, 8'h00, 0, 1, 0, 0);
        idle(2);
        wr_frame(2, 100);
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("plan_rst_cnt", {22'b0, wr_count}, 32'd0);
        chk("plan_rst_err", {31'b0, err}, 32'd0);
        wr_frame(2, D);
        cyc(0, 0, 0, 8'h00, 1, 0, 1, 2);
        cyc(0, 0, 0, 8'h00, 0, 0, 1, 2);
        idle(40);
        chk("plan_rst_err_final", {31'b0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
